vec_edge_counter: RTL and testbench

VEC_EDGE_COUNTER -- requirements
Module: vec_edge_counter

---
 rtl/vec_edge_counter.sv | 104 ++++++++++
 tb/tb_vec_edge_counter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_edge_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vec_edge_counter                                                         |
// | Per-channel rising-edge counters, sticky overflow, and a snapshot port.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vec_edge_counter #(
  parameter int NCH      = 2,
  parameter int CW       = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    chan_in,
  input  logic              enable,
  input  logic [NCH-1:0]    clear,
  output logic [NCH*CW-1:0] count,
  output logic [NCH-1:0]    overflow,
  input  logic              snap_req,
  output logic              snap_valid,
  input  logic              snap_ready,
  output logic [NCH*CW-1:0] snap_data
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NCH-1:0]    chan_q;
  logic [NCH-1:0]    ovf_q, ovf_d;
  logic [NCH*CW-1:0] count_q, count_d;
  logic [NCH*CW-1:0] snap_q, snap_d;
  logic [NCH-1:0]    rise;
  logic [CW-1:0]     cur;

  assign rise = chan_in & ~chan_q;

  // Clear wins over a coincident edge; a disabled edge is simply lost.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    cur     = '0;
    for (int i = 0; i < NCH; i++) begin
      cur = count_q[i*CW +: CW];
      if (clear[i]) begin
        count_d[i*CW +: CW] = '0;
        ovf_d[i]            = 1'b0;
      end else if (enable && rise[i]) begin
        if (cur == CNT_MAX) begin
          ovf_d[i]            = 1'b1;
          count_d[i*CW +: CW] = SATURATE ? CNT_MAX : '0;
        end else begin
          count_d[i*CW +: CW] = cur + CW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    case (state_q)
      ST_IDLE: begin
        if (snap_req) begin
          state_d = ST_HOLD;
          snap_d  = count_q;
        end
      end
      ST_HOLD: begin
        if (snap_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      ovf_q   <= '0;
      count_q <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_in;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      snap_q  <= snap_d;
    end
  end

  assign count      = count_q;
  assign overflow   = ovf_q;
  assign snap_data  = snap_q;
  assign snap_valid = (state_q == ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_vec_edge_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vec_edge_counter                                                      |
// | Scoreboard bench: wrapping and saturating instances share one stimulus.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vec_edge_counter;
  localparam int NCH  = 2;
  localparam int CW   = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] chan_in = '0;
  logic [NCH-1:0] clear = '0;
  logic enable = 1'b0;
  logic snap_req = 1'b0;
  logic snap_ready = 1'b0;
  logic [NCH*CW-1:0] count0, count1, sdata0, sdata1;
  logic [NCH-1:0] ovf0, ovf1;
  logic sv0, sv1;

  always #5 clk = ~clk;

  vec_edge_counter #(.NCH(NCH), .CW(CW), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .chan_in(chan_in), .enable(enable), .clear(clear),
    .count(count0), .overflow(ovf0), .snap_req(snap_req), .snap_valid(sv0),
    .snap_ready(snap_ready), .snap_data(sdata0));

  vec_edge_counter #(.NCH(NCH), .CW(CW), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .chan_in(chan_in), .enable(enable), .clear(clear),
    .count(count1), .overflow(ovf1), .snap_req(snap_req), .snap_valid(sv1),
    .snap_ready(snap_ready), .snap_data(sdata1));

  typedef struct packed {
    logic [NCH*CW-1:0] c0, c1;
    logic [NCH-1:0]    o0, o1;
    logic              v;
  } exp_t;
  typedef struct packed {
    logic [NCH*CW-1:0] d0, d1;
  } snap_t;

  exp_t  exp_q[$];
  snap_t snp_q[$];
  int total = 0;
  int bad = 0;

  // Reference: integer counters per instance (0 = wrap, 1 = saturate)
  int m_cnt[2][NCH];
  bit m_ovf[2][NCH];
  bit m_prev[NCH];
  bit m_hold;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endfunction

  function automatic logic [NCH*CW-1:0] pack_cnt(int s);
    logic [NCH*CW-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i*CW +: CW] = CW'(m_cnt[s][i]);
    return r;
  endfunction

  function automatic logic [NCH-1:0] pack_ovf(int s);
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i] = m_ovf[s][i];
    return r;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NCH; i++) begin
        m_cnt[s][i] = 0;
        m_ovf[s][i] = 1'b0;
      end
    for (int i = 0; i < NCH; i++) m_prev[i] = 1'b0;
    m_hold = 1'b0;
    snp_q.delete();
    exp_q.delete();
  endfunction

  // Evaluate one clock edge with the currently applied inputs.
  function automatic void model_step();
    snap_t sn;
    exp_t  e;
    if (!m_hold && snap_req) begin
      sn.d0 = pack_cnt(0);
      sn.d1 = pack_cnt(1);
      snp_q.push_back(sn);
      m_hold = 1'b1;
    end else if (m_hold && snap_ready) begin
      m_hold = 1'b0;
    end
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NCH; i++) begin
        if (clear[i]) begin
          m_cnt[s][i] = 0;
          m_ovf[s][i] = 1'b0;
        end else if (enable && chan_in[i] && !m_prev[i]) begin
          if (m_cnt[s][i] == MAXV) begin
            m_ovf[s][i] = 1'b1;
            m_cnt[s][i] = (s == 1) ? MAXV : 0;
          end else begin
            m_cnt[s][i] = m_cnt[s][i] + 1;
          end
        end
      end
    for (int i = 0; i < NCH; i++) m_prev[i] = chan_in[i];
    e.c0 = pack_cnt(0);
    e.c1 = pack_cnt(1);
    e.o0 = pack_ovf(0);
    e.o1 = pack_ovf(1);
    e.v  = m_hold;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_ch(int ch);
    chan_in[ch] = 1'b1;
    tick();
    chan_in[ch] = 1'b0;
    tick();
  endtask

  // Monitor: compares every cycle's state and each accepted snapshot.
  initial begin : monitor
    exp_t  e;
    snap_t s;
    logic pv;
    logic [NCH*CW-1:0] pd0, pd1;
    pv = 1'b0;
    pd0 = '0;
    pd1 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("count_wrap", 32'(count0), 32'(e.c0));
          chk("count_sat",  32'(count1), 32'(e.c1));
          chk("ovf_wrap",   32'(ovf0),   32'(e.o0));
          chk("ovf_sat",    32'(ovf1),   32'(e.o1));
          chk("valid_wrap", 32'(sv0),    32'(e.v));
          chk("valid_sat",  32'(sv1),    32'(e.v));
        end
        if (pv && snap_ready) begin
          if (snp_q.size() == 0) begin
            chk("snap_underflow", 32'(snp_q.size()), 32'd1);
          end else begin
            s = snp_q.pop_front();
            chk("snap_accept_wrap", 32'(pd0), 32'(s.d0));
            chk("snap_accept_sat",  32'(pd1), 32'(s.d1));
          end
        end else if (sv0 && snp_q.size() > 0) begin
          chk("snap_hold_wrap", 32'(sdata0), 32'(snp_q[0].d0));
          chk("snap_hold_sat",  32'(sdata1), 32'(snp_q[0].d1));
        end
        pv  = sv0;
        pd0 = sdata0;
        pd1 = sdata1;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_count", 32'(count0), 32'd0);
    chk("reset_valid", 32'(sv0), 32'd0);
    rst = 1'b0;
    enable = 1'b1;

    // Three single-cycle pulses on channel 0
    repeat (3) pulse_ch(0);
    chk("pulses3_count", 32'(count0), 32'h3);
    chk("pulses3_ovf", 32'(ovf0), 32'h0);

    // Five edges on channel 1 wrap once, then clear
    repeat (5) pulse_ch(1);
    chk("wrap5_count", 32'(count0), 32'h7);
    chk("wrap5_ovf", 32'(ovf0), 32'h2);
    clear = 2'b11;
    tick();
    clear = 2'b00;
    chk("clear_count", 32'(count0), 32'h0);
    chk("clear_ovf", 32'(ovf0), 32'h0);

    // Six edges on channel 0: saturating instance holds at max
    repeat (6) pulse_ch(0);
    chk("sat6_count", 32'(count1), 32'h3);
    chk("sat6_ovf", 32'(ovf1), 32'h1);
    clear = 2'b11;
    tick();
    clear = 2'b00;

    // Clear beats a coincident edge; disabled edge is not deferred
    chan_in[0] = 1'b1;
    clear[0] = 1'b1;
    tick();
    clear = 2'b00;
    chan_in[0] = 1'b0;
    tick();
    chk("clear_vs_edge", 32'(count0), 32'h0);
    enable = 1'b0;
    chan_in[0] = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    tick();
    chan_in[0] = 1'b0;
    tick();
    chk("enable_discard", 32'(count0), 32'h0);

    // Snapshot held while counting continues
    pulse_ch(0);
    pulse_ch(0);
    pulse_ch(1);
    chk("pre_snap_count", 32'(count0), 32'h6);
    snap_req = 1'b1;
    tick();
    chan_in[0] = 1'b1;
    tick();
    snap_req = 1'b0;
    chan_in[0] = 1'b0;
    tick();
    chan_in[0] = 1'b1;
    tick();
    chan_in[0] = 1'b0;
    tick();
    chk("hold_snap_data", 32'(sdata0), 32'h6);
    chk("hold_count", 32'(count0), 32'h4);
    chk("hold_ovf0", 32'(ovf0[0]), 32'h1);
    chk("hold_valid", 32'(sv0), 32'h1);
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    chk("release_valid", 32'(sv0), 32'h0);

    // snap_req ignored in the accept cycle
    snap_req = 1'b1;
    tick();
    snap_ready = 1'b1;
    tick();
    snap_req = 1'b0;
    snap_ready = 1'b0;
    tick();
    chk("req_on_accept", 32'(sv0), 32'h0);

    // Asynchronous reset during HOLD, then a high level at release
    pulse_ch(1);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_count", 32'(count0), 32'h0);
    chk("async_ovf", 32'(ovf0), 32'h0);
    chk("async_valid", 32'(sv0), 32'h0);
    chk("async_sdata", 32'(sdata0), 32'h0);
    @(negedge clk);
    chan_in = 2'b01;
    rst = 1'b0;
    tick();
    chk("release_edge", 32'(count0), 32'h1);
    chan_in = 2'b00;
    tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      chan_in    = NCH'($urandom);
      enable     = ($urandom_range(0, 7) != 0);
      clear[0]   = ($urandom_range(0, 15) == 0);
      clear[1]   = ($urandom_range(0, 15) == 0);
      snap_req   = ($urandom_range(0, 3) == 0);
      snap_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    chan_in = '0;
    clear = '0;
    snap_req = 1'b0;
    snap_ready = 1'b0;
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
